// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic instructions into RVSP words
// and streams them into instruction RAM; optional LOADER_CHECKSUM_EN.
module instr_encoder_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    op_sel,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [20:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   prog_len,
    output logic          full,
    output logic          done,
    output logic          err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]   checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_AI  = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_IN  = 7'b0110111;
    localparam logic [6:0] OP_OUT = 7'b0010111;
    localparam logic [6:0] F7_0   = 7'b0000000;
    localparam logic [6:0] F7_1   = 7'b0100000;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic [31:0]   enc_word;
    logic          enc_bad;
    logic          enc_halt;
    logic          imm_i_ok;
    logic          imm_b_ok;
    logic          accept;

    assign full      = (cnt_q == DEPTH_C);
    assign done      = (state_q == S_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign prog_len  = cnt_q;
    assign err       = err_q;

    // Encode the presented fields and flag anything that cannot be encoded
    always_comb begin
        imm_i_ok = (imm[20:11] == '0) || (imm[20:11] == '1);
        imm_b_ok = ((imm[20:12] == '0) || (imm[20:12] == '1)) && !imm[0];
        enc_word = '0;
        enc_bad  = 1'b0;
        enc_halt = 1'b0;
        case (op_sel)
            5'd0:  enc_word = {F7_0, rs2, rs1, 3'd0, rd, OP_R};
            5'd1:  enc_word = {F7_1, rs2, rs1, 3'd0, rd, OP_R};
            5'd2:  enc_word = {F7_0, rs2, rs1, 3'd1, rd, OP_R};
            5'd3:  enc_word = {F7_0, rs2, rs1, 3'd2, rd, OP_R};
            5'd4:  enc_word = {F7_0, rs2, rs1, 3'd3, rd, OP_R};
            5'd5:  enc_word = {F7_1, rs2, rs1, 3'd3, rd, OP_R};
            5'd6:  enc_word = {F7_0, rs2, rs1, 3'd4, rd, OP_R};
            5'd7:  enc_word = {F7_1, rs2, rs1, 3'd4, rd, OP_R};
            5'd8:  enc_word = {F7_0, rs2, rs1, 3'd5, rd, OP_R};
            5'd9:  enc_word = {F7_0, rs2, rs1, 3'd6, rd, OP_R};
            5'd10: enc_word = {F7_0, rs2, rs1, 3'd7, rd, OP_R};
            5'd11: begin
                enc_word = {imm[11:0], rs1, 3'd2, rd, OP_LW};
                enc_bad  = !imm_i_ok;
            end
            5'd12: begin
                enc_word = {imm[11:0], rs1, 3'd0, rd, OP_AI};
                enc_bad  = !imm_i_ok;
            end
            5'd13: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, 3'd0,
                            imm[4:1], imm[11], OP_B};
                enc_bad  = !imm_b_ok;
            end
            5'd14: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, 3'd1,
                            imm[4:1], imm[11], OP_B};
                enc_bad  = !imm_b_ok;
            end
            5'd15: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, 3'd4,
                            imm[4:1], imm[11], OP_B};
                enc_bad  = !imm_b_ok;
            end
            5'd16: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, 3'd5,
                            imm[4:1], imm[11], OP_B};
                enc_bad  = !imm_b_ok;
            end
            5'd17: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, OP_J};
                enc_bad  = imm[0];
            end
            5'd18: begin
                enc_word = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], OP_S};
                enc_bad  = !imm_i_ok;
            end
            5'd19: enc_word = {20'd0, rd, OP_IN};
            5'd20: enc_word = {20'd0, rd, OP_OUT};
            5'd21: begin
                enc_word = 32'h0000_003F;
                enc_halt = 1'b1;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    // Handshake and next-state selection
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == S_LOAD) && !full && !start;
        accept   = in_valid && in_ready;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: if (accept && enc_halt && !enc_bad) state_d = S_DONE;
            S_DONE: if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Write pointer, staged write and reject pulse
    always_comb begin
        we_d    = accept && !enc_bad;
        err_d   = accept && enc_bad;
        wdata_d = we_d ? enc_word : wdata_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (start) begin
            cnt_d  = '0;
            addr_d = '0;
        end else begin
            if (we_d) cnt_d = cnt_q + ONE_C;
            if (!full) addr_d = cnt_q[AW-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any pending write at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    assign checksum = chk_q;

    // Fold each word into the running XOR while it is being written
    always_comb begin
        chk_d = chk_q;
        if (start) begin
            chk_d = '0;
        end else if (we_q) begin
            chk_d = chk_q ^ wdata_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control unit's instruction decode: takes symbolic instructions (mnemonic select, rd, rs1, rs2, immediate) over a valid/ready stream.
- Encodes each into the 32-bit RVSP machine word (opcode/f3/f7 fields that the decoder consumes).
- Writes words sequentially into instruction memory from address 0.
- Sits between the host/boot interface and the instruction RAM; the program is finished by a HALT word.

Parameters:
- DEPTH, 256, instruction memory depth in words; number of writable slots.
- AW, 8, memory address width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear address, enter LOAD
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts this cycle
- op_sel  in  5  mnemonic code (table below)
- rd, rs1, rs2  in  5 each  register indices
- imm  in  21  signed immediate, byte offset
- mem_we  out  1  instruction RAM write strobe
- mem_addr  out  AW  word address
- mem_wdata  out  32  encoded word
- prog_len  out  AW+1  words written since last start
- full  out  1  DEPTH words written
- done  out  1  HALT word written
- err  out  1  one-cycle pulse on rejected transfer

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, prog_len=0, full=0, done=0, err=0.
- States:
  - IDLE: start goes to LOAD.
  - LOAD: on accept of HALT goes to DONE.
  - DONE: start goes to LOAD.
- in_ready = (state==LOAD) && !full && !start.
- A transfer occurs when in_valid && in_ready.
- Latency 1: a word accepted at edge N has mem_we=1 with mem_addr/mem_wdata stable for the cycle after edge N.
- Back-to-back accepts allowed; throughput is 1 word/clock.
- mem_addr increments after each write; prog_len = mem_addr count incl. pending write.
- full asserts when prog_len reaches DEPTH. Further accepts are blocked; no wrap-around.
- HALT accepted in the last slot: full and done both assert.
- op_sel encoding:
  - R-type, opcode 0110011, f7|rs2|rs1|f3|rd|op:
    - 0 add f3=0 f7=0
    - 1 sub f3=0 f7=0100000
    - 2 sll f3=1
    - 3 slt f3=2 f7=0
    - 4 mul f3=3 f7=0
    - 5 div f3=3 f7=0100000
    - 6 xor f3=4 f7=0
    - 7 xnor f3=4 f7=0100000
    - 8 srl f3=5
    - 9 or f3=6
    - 10 and f3=7
  - 11 lw: I-type, opcode 0000011, f3=2, imm[11:0].
  - 12 addi: I-type, opcode 0010011, f3=0.
  - 13..16 beq/bne/blt/bge: B-type, opcode 1100011, f3=0/1/4/5, standard scatter of imm[12:1].
  - 17 jal: J-type, opcode 1101111, rd, standard scatter of imm[20:1].
  - 18 sw: S-type, opcode 0100011, f3=2, imm[11:5]/imm[4:0].
  - 19 IN: opcode 0110111, rd in [11:7], other bits 0.
  - 20 OUT: opcode 0010111, rd in [11:7], other bits 0.
  - 21 HALT: 0x0000003F.
- Rejection (err pulses 1 cycle after accept; no write, no address change; transfer is still consumed):
  - op_sel > 21.
  - B/J type with imm[0]=1.
  - I/S imm outside -2048..2047.
  - B imm outside -4096..4094.
- Unused fields are forced to 0 (e.g. rs2 for I-type, rd for S/B).
- start in LOAD (restart):
  - in_ready=0 that cycle.
  - An already pending write still issues at its old address.
  - After that, mem_addr, prog_len, full and done clear.
- start in DONE: clears done, mem_addr and prog_len.
- in_valid while not in LOAD: ignored; in_ready=0.
- rst_n low mid-operation: immediate return to reset values; any pending write is dropped (mem_we=0 asynchronously).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Extra output checksum [31:0], reset 0.
  - Each written word is XORed in during the write cycle.
  - Cleared by start.
  - Enables an end-to-end compare by the host.
- When undefined: no port, no logic; all other behaviour identical.

Test Plan:
- start; add rd=3 rs1=1 rs2=2 -> mem_we at addr 0, wdata 0x002081B3 one cycle after accept; sub same regs -> 0x402081B3 at addr 1.
- lw rd=5 rs1=1 imm=8 -> 0x0080A283; beq rs1=1 rs2=2 imm=8 -> 0x00208463; back-to-back valid gives mem_we high on consecutive cycles with addr 0,1.
- HALT -> 0x0000003F written, done=1, in_ready=0; new in_valid produces no write; start -> done=0, prog_len=0, next word at addr 0.
- DEPTH=4: accept 4 adds -> full=1 after the 4th, in_ready=0, prog_len=4, no 5th write at any address.
- op_sel=25 and beq imm=3 -> err pulse each, mem_we stays 0, prog_len unchanged; addi imm=4096 -> err.
- rst_n pulled low during the cycle a write is pending -> mem_we=0 immediately, all outputs at reset values; with LOADER_CHECKSUM_EN, writing 0x002081B3 then 0x402081B3 gives checksum 0x40000000.
